amem_pass: RTL and testbench

A-memory datapath stage, directly downstream of the A-control block. Consumes aadr, arp and awp, and holds the 1024x32 A scratchpad. Adds a one-deep posted-write buffer with read pass-around, so a read that follows a write to the same location returns the new data. Drives the registered A bus to the ALU/source muxes.

---
 rtl/amem_pass.sv | 86 ++++++++
 tb/tb_amem_pass.sv | 164 ++++++++++++++++
 2 files changed

// File: rtl/amem_pass.sv
// A-memory datapath stage: 2**AWIDTH x DWIDTH scratchpad behind a one-deep posted-write
// buffer, with read pass-around so a read right after a write sees the new data.
module amem_pass #(
  parameter int AWIDTH = 10,
  parameter int DWIDTH = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [AWIDTH-1:0] aadr,
  input  logic              arp,
  input  logic              awp,
  input  logic [DWIDTH-1:0] l,
  output logic [DWIDTH-1:0] a,
  output logic              apass,
  output logic              pend
);

  logic [DWIDTH-1:0] mem [2**AWIDTH];

  logic              pend_q, pend_d;
  logic [AWIDTH-1:0] pendAdr_q, pendAdr_d;
  logic [DWIDTH-1:0] pendData_q, pendData_d;
  logic [DWIDTH-1:0] a_q;
  logic              apass_q;

  logic commitEn;
  logic readEn;
  logic hit;

  // A simultaneous write strobe wins over a read; the read is dropped and a/apass hold.
  assign readEn   = arp & ~awp;
  assign hit      = pend_q && (pendAdr_q == aadr);
  assign commitEn = pend_q & ~reset;

  // The buffer always drains one edge after capture; a new write refills it on the same edge.
  always_comb begin
    pend_d     = pend_q;
    pendAdr_d  = pendAdr_q;
    pendData_d = pendData_q;
    if (awp) begin
      pend_d     = 1'b1;
      pendAdr_d  = aadr;
      pendData_d = l;
    end else if (pend_q) begin
      pend_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      pend_q <= 1'b0;
    end else begin
      pend_q <= pend_d;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      pendAdr_q  <= pendAdr_d;
      pendData_q <= pendData_d;
    end
  end

  // Single write port; reset throws away the buffered entry instead of committing it.
  always_ff @(posedge clk) begin
    if (commitEn) begin
      mem[pendAdr_q] <= pendData_q;
    end
  end

  // The array read samples the value from before this edge's commit; the bypass covers that gap.
  always_ff @(posedge clk) begin
    if (reset) begin
      a_q     <= '0;
      apass_q <= 1'b0;
    end else if (readEn) begin
      a_q     <= hit ? pendData_q : mem[aadr];
      apass_q <= hit;
    end
  end

  assign a     = a_q;
  assign apass = apass_q;
  assign pend  = pend_q;

endmodule

// File: tb/tb_amem_pass.sv
// Self-checking bench for amem_pass: directed scenarios with fixed expectations, then a
// random read/write mix scored against a small behavioural model of the buffer and array.
module tb_amem_pass;

  logic        clk;
  logic        reset;
  logic [9:0]  aadr;
  logic        arp;
  logic        awp;
  logic [31:0] l;
  logic [31:0] a;
  logic        apass;
  logic        pend;

  int assertCount = 0;
  int failCount   = 0;

  logic [33:0] sbQ [$];

  logic [31:0] modelMem [int];
  logic        modelPend;
  logic [9:0]  modelPendAdr;
  logic [31:0] modelPendData;
  logic [31:0] modelA;
  logic        modelPass;

  amem_pass #(.AWIDTH(10), .DWIDTH(32)) dut (
    .clk   (clk),
    .reset (reset),
    .aadr  (aadr),
    .arp   (arp),
    .awp   (awp),
    .l     (l),
    .a     (a),
    .apass (apass),
    .pend  (pend)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    assertCount++;
    if (observed !== expected) begin
      failCount++;
      $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", tag, observed, expected);
    end
  endtask

  // Outside reset the two strobes must never coincide; any such edge is an error.
  always @(posedge clk) begin
    if (reset === 1'b0 && arp === 1'b1 && awp === 1'b1) begin
      checkOutput("protocolArpAwp", 32'd1, 32'd0);
    end
  end

  // Drive one cycle, queue what the outputs must look like after the edge, then score it.
  task automatic applyStimulus(input string tag, input logic rst, input logic rp, input logic wp,
                               input logic [9:0] adr, input logic [31:0] data,
                               input logic [31:0] expA, input logic expPass, input logic expPend);
    logic [33:0] item;
    reset = rst;
    arp   = rp;
    awp   = wp;
    aadr  = adr;
    l     = data;
    sbQ.push_back({expA, expPass, expPend});
    @(posedge clk);
    #1;
    if (sbQ.size() == 0) begin
      checkOutput({tag, ".queueEmpty"}, 32'd1, 32'd0);
    end else begin
      item = sbQ.pop_front();
      checkOutput({tag, ".a"}, a, item[33:2]);
      checkOutput({tag, ".apass"}, {31'd0, apass}, {31'd0, item[1]});
      checkOutput({tag, ".pend"}, {31'd0, pend}, {31'd0, item[0]});
    end
  endtask

  // Reference behaviour for the random phase: expectations are computed before the edge.
  task automatic modelStep(input string tag, input logic rp, input logic wp,
                           input logic [9:0] adr, input logic [31:0] data);
    logic hitM;
    if (rp && !wp) begin
      hitM      = modelPend && (modelPendAdr == adr);
      modelA    = hitM ? modelPendData : modelMem[int'(adr)];
      modelPass = hitM;
    end
    if (modelPend) modelMem[int'(modelPendAdr)] = modelPendData;
    if (wp) begin
      modelPend     = 1'b1;
      modelPendAdr  = adr;
      modelPendData = data;
    end else begin
      modelPend = 1'b0;
    end
    applyStimulus(tag, 1'b0, rp, wp, adr, data, modelA, modelPass, modelPend);
  endtask

  // Directed scenarios first, then a randomised mix over a small set of preloaded addresses.
  initial begin
    reset = 1'b1;
    arp   = 1'b0;
    awp   = 1'b0;
    aadr  = '0;
    l     = '0;

    applyStimulus("reset0", 1'b1, 1'b1, 1'b1, 10'h000, 32'hFFFFFFFF, 32'h0, 1'b0, 1'b0);
    applyStimulus("reset1", 1'b1, 1'b1, 1'b1, 10'h000, 32'hFFFFFFFF, 32'h0, 1'b0, 1'b0);
    applyStimulus("release", 1'b0, 1'b0, 1'b0, 10'h000, 32'h0, 32'h0, 1'b0, 1'b0);

    applyStimulus("wr005", 1'b0, 1'b0, 1'b1, 10'h005, 32'hDEADBEEF, 32'h0, 1'b0, 1'b1);
    applyStimulus("idle005", 1'b0, 1'b0, 1'b0, 10'h000, 32'h0, 32'h0, 1'b0, 1'b0);
    applyStimulus("rd005", 1'b0, 1'b1, 1'b0, 10'h005, 32'h0, 32'hDEADBEEF, 1'b0, 1'b0);

    applyStimulus("wr3FF", 1'b0, 1'b0, 1'b1, 10'h3FF, 32'h12345678, 32'hDEADBEEF, 1'b0, 1'b1);
    applyStimulus("rdPass3FF", 1'b0, 1'b1, 1'b0, 10'h3FF, 32'h0, 32'h12345678, 1'b1, 1'b0);
    applyStimulus("holdOnWrite", 1'b0, 1'b0, 1'b1, 10'h100, 32'h0BADF00D, 32'h12345678, 1'b1, 1'b1);
    applyStimulus("rdArr3FF", 1'b0, 1'b1, 1'b0, 10'h3FF, 32'h0, 32'h12345678, 1'b0, 1'b0);

    applyStimulus("wr010", 1'b0, 1'b0, 1'b1, 10'h010, 32'hA5A5A5A5, 32'h12345678, 1'b0, 1'b1);
    applyStimulus("idle010", 1'b0, 1'b0, 1'b0, 10'h000, 32'h0, 32'h12345678, 1'b0, 1'b0);
    applyStimulus("wr011", 1'b0, 1'b0, 1'b1, 10'h011, 32'h00000001, 32'h12345678, 1'b0, 1'b1);
    applyStimulus("rdMiss010", 1'b0, 1'b1, 1'b0, 10'h010, 32'h0, 32'hA5A5A5A5, 1'b0, 1'b0);
    applyStimulus("rd011", 1'b0, 1'b1, 1'b0, 10'h011, 32'h0, 32'h00000001, 1'b0, 1'b0);

    applyStimulus("wr020a", 1'b0, 1'b0, 1'b1, 10'h020, 32'h11111111, 32'h00000001, 1'b0, 1'b1);
    applyStimulus("wr020b", 1'b0, 1'b0, 1'b1, 10'h020, 32'h22222222, 32'h00000001, 1'b0, 1'b1);
    applyStimulus("rdPass020", 1'b0, 1'b1, 1'b0, 10'h020, 32'h0, 32'h22222222, 1'b1, 1'b0);
    applyStimulus("idle020", 1'b0, 1'b0, 1'b0, 10'h000, 32'h0, 32'h22222222, 1'b1, 1'b0);
    applyStimulus("rdArr020", 1'b0, 1'b1, 1'b0, 10'h020, 32'h0, 32'h22222222, 1'b0, 1'b0);

    applyStimulus("wr030zero", 1'b0, 1'b0, 1'b1, 10'h030, 32'h00000000, 32'h22222222, 1'b0, 1'b1);
    applyStimulus("idle030", 1'b0, 1'b0, 1'b0, 10'h000, 32'h0, 32'h22222222, 1'b0, 1'b0);
    applyStimulus("wr030new", 1'b0, 1'b0, 1'b1, 10'h030, 32'hCAFEF00D, 32'h22222222, 1'b0, 1'b1);
    applyStimulus("resetMid", 1'b1, 1'b0, 1'b0, 10'h000, 32'h0, 32'h0, 1'b0, 1'b0);
    applyStimulus("rd030", 1'b0, 1'b1, 1'b0, 10'h030, 32'h0, 32'h00000000, 1'b0, 1'b0);

    modelPend     = 1'b0;
    modelPendAdr  = '0;
    modelPendData = '0;
    modelA        = 32'h0;
    modelPass     = 1'b0;
    for (int i = 0; i < 8; i++) begin
      modelStep("preload", 1'b0, 1'b1, 10'h040 + 10'(i), $urandom);
    end
    modelStep("preloadIdle", 1'b0, 1'b0, 10'h000, 32'h0);
    for (int i = 0; i < 80; i++) begin
      int op;
      logic [9:0] adr;
      op  = $urandom_range(0, 2);
      adr = 10'h040 + 10'($urandom_range(0, 7));
      case (op)
        0:       modelStep("randRead", 1'b1, 1'b0, adr, 32'h0);
        1:       modelStep("randWrite", 1'b0, 1'b1, adr, $urandom);
        default: modelStep("randIdle", 1'b0, 1'b0, adr, 32'h0);
      endcase
    end

    $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
    $finish;
  end

endmodule
